// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Execute/writeback boundary sitting directly behind the 32-bit ALU. Results
// are captured into a two-entry skid buffer (head + skid) with a valid/ready
// handshake toward writeback, and the architectural flag register is updated
// at accept time from the ALU flag outputs.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous pipeline flush (beats accept and pop)
//   in_valid/in_ready  upstream handshake; in_ready depends on state only
//   in_result          ALU result
//   in_op_code         opcode that produced in_result (0 / reserved = NOP)
//   in_dest            destination register tag
//   in_flag_we         this op writes the flag register
//   in_flag_*          ALU carry / overflow / parity / negative flags
//   out_valid/ready    downstream handshake toward writeback
//   out_result/op_code/dest   head entry fields
//   flags_q            {zero, neg, parity, overflow, carry}
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [OP_W-1:0]   in_op_code,
    input  logic [TAG_W-1:0]  in_dest,
    input  logic              in_flag_we,
    input  logic              in_flag_carry,
    input  logic              in_flag_overflow,
    input  logic              in_flag_parity,
    input  logic              in_flag_neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [OP_W-1:0]   out_op_code,
    output logic [TAG_W-1:0]  out_dest,
    output logic [4:0]        flags_q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] head_result_reg, skid_result_reg;
    logic [OP_W-1:0]   head_op_reg,     skid_op_reg;
    logic [TAG_W-1:0]  head_dest_reg,   skid_dest_reg;
    logic [4:0]        flags_reg;

    logic op_live;      // opcode produces a real result (not NOP / reserved)
    logic accept;
    logic pop;
    logic enq;          // accepted, live, and not killed by flush
    logic load_head_in;
    logic load_head_skid;
    logic load_skid;
    logic flag_update;

    // Opcode 0, 10..15 and 20..31 carry no result; they complete the
    // handshake but leave the buffer and flags untouched.
    always_comb begin
        op_live = (in_op_code != '0)
               && !((in_op_code >= OP_W'(10)) && (in_op_code <= OP_W'(15)))
               && !(in_op_code >= OP_W'(20));
    end

    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign enq         = accept & op_live & ~flush;
    assign flag_update = enq & in_flag_we;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: if (enq) state_next = ONE;
                ONE: begin
                    if (enq && !pop)      state_next = TWO;
                    else if (!enq && pop) state_next = EMPTY;
                end
                TWO:   if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // ---------------- output logic (state only) ----------------
    always_comb begin
        out_valid = (state_reg != EMPTY);
        in_ready  = (state_reg != TWO);
    end

    // Head is written from the input when it is empty or being drained this
    // cycle; otherwise a new entry parks in the skid slot. A pop out of TWO
    // promotes the skid entry to head.
    always_comb begin
        load_head_in   = enq && ((state_reg == EMPTY) || ((state_reg == ONE) && pop));
        load_skid      = enq && (state_reg == ONE) && !pop;
        load_head_skid = !flush && (state_reg == TWO) && pop;
    end

    // ---------------- data path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result_reg <= '0;
            head_op_reg     <= '0;
            head_dest_reg   <= '0;
            skid_result_reg <= '0;
            skid_op_reg     <= '0;
            skid_dest_reg   <= '0;
        end else begin
            if (load_head_in) begin
                head_result_reg <= in_result;
                head_op_reg     <= in_op_code;
                head_dest_reg   <= in_dest;
            end else if (load_head_skid) begin
                head_result_reg <= skid_result_reg;
                head_op_reg     <= skid_op_reg;
                head_dest_reg   <= skid_dest_reg;
            end
            if (load_skid) begin
                skid_result_reg <= in_result;
                skid_op_reg     <= in_op_code;
                skid_dest_reg   <= in_dest;
            end
        end
    end

    // ---------------- flag register ----------------
    // Updated when the op is accepted, independent of when writeback pops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 5'b00000;
        end else if (flag_update) begin
            flags_reg <= {(in_result == '0), in_flag_neg, in_flag_parity,
                          in_flag_overflow, in_flag_carry};
        end
    end

    assign out_result  = head_result_reg;
    assign out_op_code = head_op_reg;
    assign out_dest    = head_dest_reg;
    assign flags_q     = flags_reg;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute/writeback pipeline boundary placed directly downstream of the 32-bit ALU.
- Registers the ALU result, opcode and destination tag into a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Maintains the architectural flag register (carry, overflow, parity, neg, zero), updated from the ALU flag outputs.

Parameters:
DATA_W, 32, width of the ALU result and output data
TAG_W, 5, width of the destination register tag
OP_W, 5, width of the ALU opcode

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept this cycle
in_result  input  DATA_W  ALU out
in_op_code  input  OP_W  opcode that produced in_result
in_dest  input  TAG_W  destination register tag
in_flag_we  input  1  this op updates the flag register
in_flag_carry  input  1  ALU carry
in_flag_overflow  input  1  ALU overflow
in_flag_parity  input  1  ALU even parity (1 = valid)
in_flag_neg  input  1  ALU negative
out_valid  output  1  entry presented to writeback
out_ready  input  1  writeback accepts
out_result  output  DATA_W  head entry result
out_op_code  output  OP_W  head entry opcode
out_dest  output  TAG_W  head entry tag
flags_q  output  5  {zero, neg, parity, overflow, carry}

Behaviour:
- Reset (rst_n low, asynchronous):
  - state EMPTY; out_valid 0; out_result/out_op_code/out_dest 0; flags_q 5'b00000.
  - in_ready reads 1 during reset, but no transfer occurs while rst_n is low.
- Handshake:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = !skid_full, driven from registered state only; no combinational path from out_ready.
- States:
  - EMPTY: out_valid 0, in_ready 1.
  - ONE: head valid, in_ready 1.
  - TWO: head and skid both valid, in_ready 0.
- Transitions (non-NOP accepts only):
  - EMPTY + accept -> ONE.
  - ONE + accept & !pop -> TWO.
  - ONE + pop & !accept -> EMPTY.
  - ONE + accept & pop -> ONE (head replaced by the new entry).
  - TWO + pop -> ONE (skid moves to head).
  - TWO never accepts.
- Latency and throughput:
  - An entry accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY, or was ONE with a pop in cycle N.
  - Sustained throughput is 1 entry per cycle while out_ready stays high.
- Ordering: strict FIFO; out_* is stable while out_valid & !out_ready.
- NOP (in_op_code == 0):
  - Accepted (it consumes the handshake) but not enqueued.
  - Never updates flags, even with in_flag_we = 1.
- Reserved opcodes 10-15 and 20-31: handled the same as NOP (ALU drives 0 for these).
- Flag register update, on accept of a non-NOP/non-reserved op with in_flag_we = 1:
  - zero <= (in_result == 0); neg, parity, overflow and carry copied from the inputs.
  - Update happens at accept time, independent of writeback pop.
  - Otherwise flags_q holds its value.
- Flush (synchronous):
  - Next state EMPTY and out_valid 0.
  - A same-cycle accept is dropped and does not update flags.
  - flags_q is retained.
  - flush has priority over accept and pop.
- Reset asserted mid-operation: all entries and flags are cleared immediately.

Test Plan:
- Reset, then a single accept with in_result=0x00000000, op 16, dest 3, in_flag_we=1, out_ready=1 -> out_valid=1 next cycle with out_result=0, out_dest=3; flags_q=5'b10000 plus the input flags; out_valid=0 the following cycle.
- Hold out_ready=0 and push results 0xA, 0xB, 0xC on consecutive cycles -> 0xA and 0xB accepted, in_ready=0 on the third cycle; release out_ready -> outputs 0xA then 0xB in order, then 0xC is accepted.
- Stream 8 back-to-back ADDs with out_ready=1 -> 8 outputs on consecutive cycles, in_ready held at 1 throughout, no bubbles.
- NOP and op 12 with in_valid=1 and in_flag_we=1 -> in_ready stays 1, out_valid stays 0, flags_q unchanged.
- Two entries buffered, assert flush together with in_valid -> out_valid=0 next cycle, the input is lost, flags_q unchanged, in_ready=1.
- Assert rst_n low asynchronously while the stage is in TWO -> out_valid and flags_q go to 0 without waiting for a clock edge.
